aes_key_schedule: RTL and testbench



---
 rtl/aes_pkg.sv | 55 +++++
 rtl/KeyGeneration.sv | 36 +++
 rtl/aes_key_schedule.sv | 117 +++++++++++
 tb/tb_aes_key_schedule.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule types, constants and GF(2^8) helpers
package aes_pkg;

    localparam int NR  = 10;
    localparam int NRK = 11;
    localparam int KW  = 128;

    typedef enum logic [1:0] {IDLE, SUB, CAP, DONE} state_t;
    typedef logic [127:0] rk_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 by square-and-multiply, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/KeyGeneration.sv
// rtl/KeyGeneration.sv - one AES-128 key-expansion round with registered S-box stage
module KeyGeneration
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] rc,
    input  rk_t        key_in,
    output rk_t        keyout
);

    logic [31:0] r_sub;
    logic [31:0] w_rot;
    logic [31:0] w_t;
    logic [31:0] w_n0;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;

    assign w_rot = {key_in[23:0], key_in[31:24]};

    // key_in and rc are held by the caller until keyout is consumed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            r_sub[8*i +: 8] <= sbox(w_rot[8*i +: 8]);
        end
    end

    assign w_t  = r_sub ^ {rcon(rc), 24'h000000};
    assign w_n0 = key_in[127:96] ^ w_t;
    assign w_n1 = key_in[95:64]  ^ w_n0;
    assign w_n2 = key_in[63:32]  ^ w_n1;
    assign w_n3 = key_in[31:0]   ^ w_n2;

    assign keyout = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - sequential AES-128 key expansion with 11-entry round-key file
module aes_key_schedule #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic          rd_en,
    input  logic [3:0]    rd_addr,
    output logic [KW-1:0] rd_key,
    output logic          rd_valid
);

    import aes_pkg::*;

    state_t        r_state;
    state_t        w_next;
    logic          w_busy;
    logic          w_done;
    logic          w_accept;
    logic          w_last;
    logic [KW-1:0] r_cur_key;
    logic [3:0]    r_rc;
    logic [KW-1:0] r_rk [NRK];
    logic          r_keys_valid;
    logic [KW-1:0] r_rd_key;
    logic          r_rd_valid;
    logic [KW-1:0] w_keyout;
    logic [KW-1:0] w_rd_mux;

    KeyGeneration u_keygen (
        .clk    (clk),
        .rc     (r_rc),
        .key_in (r_cur_key),
        .keyout (w_keyout)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_rc == 4'(NR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = SUB;
            SUB: begin
                w_busy = 1'b1;
                w_next = CAP;
            end
            CAP: begin
                w_busy = 1'b1;
                w_next = w_last ? DONE : SUB;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NRK; i++) begin
            if (rd_addr == 4'(i)) w_rd_mux = r_rk[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_key    <= '0;
            r_rc         <= 4'd0;
            r_keys_valid <= 1'b0;
            r_rd_key     <= '0;
            r_rd_valid   <= 1'b0;
            for (int i = 0; i < NRK; i++) r_rk[i] <= '0;
        end else begin
            if (w_accept) begin
                r_cur_key    <= key_in;
                r_rk[0]      <= key_in;
                r_rc         <= 4'd0;
                r_keys_valid <= 1'b0;
            end
            if (r_state == CAP) begin
                r_cur_key <= w_keyout;
                for (int i = 1; i < NRK; i++) begin
                    if (r_rc == 4'(i - 1)) r_rk[i] <= w_keyout;
                end
                if (w_last) r_keys_valid <= 1'b1;
                else        r_rc <= r_rc + 4'd1;
            end
            // Out-of-range or incomplete-schedule reads return zero but still respond.
            if (rd_en) begin
                r_rd_key <= (rd_addr <= 4'(NRK - 1) && r_keys_valid) ? w_rd_mux : '0;
            end
            r_rd_valid <= rd_en;
        end
    end

    assign busy       = w_busy;
    assign done       = w_done;
    assign keys_valid = r_keys_valid;
    assign rd_key     = r_rd_key;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - self-checking bench for aes_key_schedule against a table-driven FIPS-197 model
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_addr = 4'd0;
    logic [127:0] rd_key;
    logic         rd_valid;

    int errors = 0;
    int checks = 0;
    int lat = 0;

    logic [127:0] exp_rk [11];
    logic [127:0] got [11];
    logic         gotv [11];

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_key_schedule #(.NR(10), .KW(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_rows[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        int rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 1;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc[7:0];
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && lat < 60) step();
    endtask

    task automatic rd(input logic [3:0] a);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < 11; r++) begin
            rd(4'(r));
            got[r]  = rd_key;
            gotv[r] = rd_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, keys_valid, rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, keys_valid, rd_valid});
        end
        checks++;
        if (rd_key !== '0) begin
            errors++;
            $display("FAIL reset_rd_key: got %h want 0", rd_key);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd5);
        checks++;
        if (rd_key !== '0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_read: got key %h valid %b want 0 / 1", rd_key, rd_valid);
        end
    endtask

    task automatic test_fips();
        model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        checks++;
        if (busy !== 1'b1 || keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_busy_rise: got busy %b kv %b want 1 / 0", busy, keys_valid);
        end
        wait_done();
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL fips_latency: got %0d want 21", lat);
        end
        checks++;
        if (busy !== 1'b0 || keys_valid !== 1'b1) begin
            errors++;
            $display("FAIL fips_done_flags: got busy %b kv %b want 0 / 1", busy, keys_valid);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: got %b want 0", done);
        end
        read_all();
        checks++;
        if (got[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++;
            $display("FAIL fips_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", got[0]);
        end
        checks++;
        if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", got[1]);
        end
        checks++;
        if (got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]);
        end
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (got[r] !== exp_rk[r] || gotv[r] !== 1'b1) begin
                errors++;
                $display("FAIL fips_model_rk%0d: got %h/%b want %h/1", r, got[r], gotv[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] ka;
        ka = rand_key();
        model_expand(ka);
        start_key(ka);
        while (lat < 5) step();
        start  = 1'b1;
        key_in = rand_key();
        step();
        start = 1'b0;
        wait_done();
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL ignored_latency: got %0d want 21", lat);
        end
        read_all();
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (got[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL ignored_rk%0d: got %h want %h", r, got[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] kc;
        start_key(rand_key());
        while (lat < 12) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, keys_valid, rd_valid} !== 4'b0000 || rd_key !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got flags %b key %h want 0000 / 0",
                     {busy, done, keys_valid, rd_valid}, rd_key);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(4'd3);
        checks++;
        if (rd_key !== '0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rd3: got key %h valid %b want 0 / 1", rd_key, rd_valid);
        end
        kc = rand_key();
        model_expand(kc);
        start_key(kc);
        wait_done();
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL midreset_latency: got %0d want 21", lat);
        end
        read_all();
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (got[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL midreset_rk%0d: got %h want %h", r, got[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [127:0] kd;
        rd(4'd11);
        checks++;
        if (rd_key !== '0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd11: got key %h valid %b want 0 / 1", rd_key, rd_valid);
        end
        rd(4'd15);
        checks++;
        if (rd_key !== '0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd15: got key %h valid %b want 0 / 1", rd_key, rd_valid);
        end
        kd = rand_key();
        model_expand(kd);
        start_key(kd);
        rd(4'd2);
        checks++;
        if (rd_key !== '0 || rd_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_read: got key %h valid %b busy %b want 0 / 1 / 1", rd_key, rd_valid, busy);
        end
        wait_done();
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL busy_read_latency: got %0d want 21", lat);
        end
        read_all();
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (got[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL busy_read_rk%0d: got %h want %h", r, got[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka;
        ka = rand_key();
        model_expand(ka);
        start_key(ka);
        wait_done();
        rd_en   = 1'b1;
        rd_addr = 4'd10;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_key !== exp_rk[10] || rd_valid !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL read_on_done: got %h/%b done %b want %h/1 done 0",
                     rd_key, rd_valid, done, exp_rk[10]);
        end
        start_key(128'h0);
        checks++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got kv %b busy %b want 0 / 1", keys_valid, busy);
        end
        model_expand(128'h0);
        wait_done();
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 21", lat);
        end
        read_all();
        checks++;
        if (got[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL b2b_zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", got[10]);
        end
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (got[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL b2b_rk%0d: got %h want %h", r, got[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] k;
        for (int n = 0; n < 3; n++) begin
            k = rand_key();
            model_expand(k);
            start_key(k);
            wait_done();
            checks++;
            if (lat !== 21) begin
                errors++;
                $display("FAIL random%0d_latency: got %0d want 21", n, lat);
            end
            read_all();
            for (int r = 0; r < 11; r++) begin
                checks++;
                if (got[r] !== exp_rk[r]) begin
                    errors++;
                    $display("FAIL random%0d_rk%0d: got %h want %h", n, r, got[r], exp_rk[r]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_start_ignored();
        test_reset_mid();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
